// File: rtl/ram_word_master_if.sv
// Bus bundle between the double-width requester, the word master and the RAM port.
// The master modport is the controller's view; the slave modport is the requester/RAM side.
interface ram_word_master_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SPACE = 16
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDR_SPACE-1:0]     req_addr;
  logic [2*DATA_WIDTH-1:0]   req_wdata;
  logic                      rsp_valid;
  logic [2*DATA_WIDTH-1:0]   rsp_rdata;
  logic [ADDR_SPACE-1:0]     mem_address;
  logic [DATA_WIDTH-1:0]     mem_data;
  logic                      mem_wren;
  logic [DATA_WIDTH-1:0]     mem_q;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mem_q,
    output req_ready, rsp_valid, rsp_rdata, mem_address, mem_data, mem_wren
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mem_q,
    input  req_ready, rsp_valid, rsp_rdata, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/ram_word_master.sv
// Splits each double-width read/write request into two consecutive single-word RAM
// accesses (low half at addr, high half at addr+1) and reassembles read results.
module ram_word_master #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SPACE = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  ram_word_master_if.master   bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_SPACE;

  typedef enum logic [1:0] {IDLE, LO, HI, TAIL} state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [2*DW-1:0]   wdata_q, wdata_d;
  logic [AW-1:0]     mem_address_q, mem_address_d;
  logic [DW-1:0]     mem_data_q, mem_data_d;
  logic              mem_wren_q, mem_wren_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [2*DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0]     addr_inc;

  // Natural width truncation gives the modulo wrap of the high-half address.
  assign addr_inc = addr_q + AW'(1);

  // RAM drive values are computed one cycle early so every mem_* output is a flop.
  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d       = LO;
          write_d       = bus.req_write;
          addr_d        = bus.req_addr;
          wdata_d       = bus.req_wdata;
          mem_address_d = bus.req_addr;
          mem_data_d    = bus.req_wdata[DW-1:0];
          mem_wren_d    = bus.req_write;
        end
      end
      LO: begin
        state_d       = HI;
        mem_address_d = addr_inc;
        mem_data_d    = wdata_q[2*DW-1:DW];
        mem_wren_d    = write_q;
      end
      HI: begin
        // RAM output now carries the word addressed during LO.
        if (write_q) begin
          state_d = IDLE;
        end else begin
          state_d              = TAIL;
          rsp_rdata_d[DW-1:0]  = bus.mem_q;
        end
      end
      TAIL: begin
        state_d                 = IDLE;
        rsp_rdata_d[2*DW-1:DW]  = bus.mem_q;
        rsp_valid_d             = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      mem_wren_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.mem_address = mem_address_q;
  assign bus.mem_data    = mem_data_q;
  assign bus.mem_wren    = mem_wren_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
endmodule
